// File: rtl/wait_sequencer_if.sv
// Z80 wait-control bus shared by the CPU side and the wait sequencer.
//   nm1      : Z80 /M1, active-low (driven by the CPU)
//   niorq    : Z80 /IORQ, active-low (driven by the CPU)
//   nextwait : external wait requests, one bit per device, active-low
//   nwait    : Z80 /WAIT, active-low (driven by the sequencer)
// The master modport is the CPU/device side; the slave modport is the sequencer.
interface wait_sequencer_if;
    logic       nm1;
    logic       niorq;
    logic [3:0] nextwait;
    logic       nwait;

    modport master (
        output nm1,
        output niorq,
        output nextwait,
        input  nwait
    );

    modport slave (
        input  nm1,
        input  niorq,
        input  nextwait,
        output nwait
    );
endinterface

// File: rtl/wait_sequencer.sv
// Z80 wait-state sequencer.
// Inserts a configurable number of wait states on every opcode fetch (M1) and
// every I/O cycle, and passes external per-device wait requests straight
// through to /WAIT. An external request that is held for TIMEOUT clocks is
// masked until it is released, and a sticky timeout flag is raised.
//
// Ports:
//   clk         : Z80 CPU clock, all state updates on its rising edge
//   nrst        : asynchronous active-low reset
//   bus         : slave side of wait_sequencer_if (nm1, niorq, nextwait -> nwait)
//   m1_waits    : wait states per opcode fetch (0-3), sampled at M1 start
//   io_waits    : wait states per I/O cycle (0-7), sampled at I/O start
//   timeout_clr : one-clock active-high clear of the timeout flag
//   timeout     : sticky flag, an external request hit TIMEOUT
module wait_sequencer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   nrst,
    wait_sequencer_if.slave        bus,
    input  logic [1:0]             m1_waits,
    input  logic [2:0]             io_waits,
    input  logic                   timeout_clr,
    output logic                   timeout
);

    localparam logic [7:0] TimeoutCount = 8'(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StInsert} state_e;

    state_e     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       prev_nm1_q, prev_niorq_q;
    logic       m1_armed_q;
    logic [7:0] tcnt_q, tcnt_d;
    logic       mask_q, mask_d;
    logic       timeout_q, timeout_d;

    logic       m1_start, io_start, start;
    logic [2:0] start_count;
    logic       any_req, ext_active, wait_int, timeout_set;

    // Start detection. m1_armed_q blocks an M1 start after reset until nm1 has
    // been seen high, so a reset released in the middle of an M1 cycle waits
    // for the next genuine falling edge of nm1.
    // An I/O start needs nm1 high, so an interrupt acknowledge (nm1 and niorq
    // both low) only ever gets the M1 start it already took.
    assign m1_start    = ~bus.nm1 & prev_nm1_q & m1_armed_q;
    assign io_start    = ~bus.niorq & prev_niorq_q & bus.nm1;
    assign start       = m1_start | io_start;
    assign start_count = m1_start ? {1'b0, m1_waits} : io_waits;

    assign any_req     = ~&bus.nextwait;
    assign ext_active  = any_req & ~mask_q;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            count_q      <= 3'd0;
            prev_nm1_q   <= 1'b1;
            prev_niorq_q <= 1'b1;
            m1_armed_q   <= 1'b0;
            tcnt_q       <= 8'd0;
            mask_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            prev_nm1_q   <= bus.nm1;
            prev_niorq_q <= bus.niorq;
            if (bus.nm1) begin
                m1_armed_q <= 1'b1;
            end
            tcnt_q       <= tcnt_d;
            mask_q       <= mask_d;
            timeout_q    <= timeout_d;
        end
    end

    // Next-state logic for the wait-insertion FSM.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (start) begin
            // A start always reloads, even mid-INSERT; a zero count stays idle.
            count_d = start_count;
            state_d = (start_count != 3'd0) ? StInsert : StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StInsert: begin
                    count_d = count_q - 3'd1;
                    if (count_q == 3'd1) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Next-state logic for the external-request timeout.
    always_comb begin
        tcnt_d      = tcnt_q;
        mask_d      = mask_q;
        timeout_set = 1'b0;
        if (!any_req) begin
            tcnt_d = 8'd0;
            mask_d = 1'b0;
        end else if (!mask_q) begin
            tcnt_d = tcnt_q + 8'd1;
            if (tcnt_d == TimeoutCount) begin
                mask_d      = 1'b1;
                timeout_set = 1'b1;
            end
        end
        // Set wins over a coincident clear.
        if (timeout_set) begin
            timeout_d = 1'b1;
        end else if (timeout_clr) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Outputs. The external path is combinational so a request reaches /WAIT
    // in the same half-cycle; internal waits are never masked.
    always_comb begin
        wait_int  = (state_q == StInsert);
        bus.nwait = ~(wait_int | ext_active);
        timeout   = timeout_q;
    end

endmodule

// File: tb/tb_wait_sequencer.sv
// Bench for wait_sequencer: directed scenarios followed by random bus traffic.
// Each cycle the stimulus process drives new inputs shortly after the rising
// edge and pushes the reference model's expected nwait/timeout; a monitor pops
// and compares on every falling edge.
module tb_wait_sequencer;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       nrst;
    logic [1:0] m1_waits;
    logic [2:0] io_waits;
    logic       timeout_clr;
    logic       timeout;

    wait_sequencer_if bus ();

    wait_sequencer #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .bus        (bus),
        .m1_waits   (m1_waits),
        .io_waits   (io_waits),
        .timeout_clr(timeout_clr),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    nwait;
        bit    to;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: wait states run for n clocks counted from the latest
    // start edge; an external request is honoured while fewer than TO
    // consecutive edges have seen it.
    bit m_prev_nm1;    // 0 after reset: nm1 must be seen high before an M1 start
    bit m_prev_niorq;
    int m_since;       // edges since the latest start
    int m_n;           // wait count of the latest start
    int m_run;         // consecutive edges with any request low
    bit m_timeout;

    task automatic model_reset();
        m_prev_nm1   = 1'b0;
        m_prev_niorq = 1'b1;
        m_since      = 1000;
        m_n          = 0;
        m_run        = 0;
        m_timeout    = 1'b0;
    endtask

    task automatic model_edge();
        bit m1s, ios, set;
        m1s = !bus.nm1 && m_prev_nm1;
        ios = !bus.niorq && m_prev_niorq && bus.nm1;
        if (m_since < 1000) m_since++;
        if (m1s) begin
            m_n = int'(m1_waits);
            m_since = 0;
        end else if (ios) begin
            m_n = int'(io_waits);
            m_since = 0;
        end
        set = 1'b0;
        if (bus.nextwait != 4'hF) begin
            if (m_run < 1000) m_run++;
            set = (m_run == TO);
        end else begin
            m_run = 0;
        end
        if (set) m_timeout = 1'b1;
        else if (timeout_clr) m_timeout = 1'b0;
        m_prev_nm1   = bus.nm1;
        m_prev_niorq = bus.niorq;
    endtask

    task automatic push_expect(input string tag);
        exp_t e;
        bit   anyreq;
        anyreq = (bus.nextwait != 4'hF);
        e.tag  = tag;
        if (!nrst) begin
            e.nwait = !anyreq;
            e.to    = 1'b0;
        end else begin
            e.nwait = !((m_since < m_n) || (anyreq && (m_run < TO)));
            e.to    = m_timeout;
        end
        sb.push_back(e);
    endtask

    // One clock: let the model see the edge, then drive the next inputs.
    task automatic step(input bit nm1, input bit niorq, input logic [3:0] nw,
                        input logic [1:0] m1w, input logic [2:0] iow, input bit clr,
                        input bit rst_n, input string tag);
        @(posedge clk);
        if (nrst) model_edge();
        #2;
        bus.nm1      = nm1;
        bus.niorq    = niorq;
        bus.nextwait = nw;
        m1_waits     = m1w;
        io_waits     = iow;
        timeout_clr  = clr;
        nrst         = rst_n;
        if (!rst_n) model_reset();
        push_expect(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1, 1, 4'hF, 2'd0, 3'd0, 0, 1, tag);
    endtask

    // Monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.nwait !== e.nwait || timeout !== e.to) begin
                    errors++;
                    $display("FAIL %s t=%0t: nwait=%b timeout=%b, required nwait=%b timeout=%b",
                             e.tag, $time, bus.nwait, timeout, e.nwait, e.to);
                end
            end
        end
    end

    initial begin
        bit         c_nm1, c_niorq, c_clr, c_rst;
        logic [3:0] c_nw;
        nrst         = 1'b0;
        bus.nm1      = 1'b1;
        bus.niorq    = 1'b1;
        bus.nextwait = 4'hF;
        m1_waits     = 2'd0;
        io_waits     = 3'd0;
        timeout_clr  = 1'b0;
        model_reset();

        step(1, 1, 4'hF, 2'd0, 3'd0, 0, 0, "reset");
        step(1, 1, 4'hF, 2'd0, 3'd0, 0, 1, "reset_release");
        idle(2, "idle");

        // One wait on an opcode fetch.
        step(0, 1, 4'hF, 2'd1, 3'd0, 0, 1, "m1w1_t1");
        step(0, 1, 4'hF, 2'd1, 3'd0, 0, 1, "m1w1_t2");
        step(0, 1, 4'hF, 2'd1, 3'd0, 0, 1, "m1w1_t3");
        step(1, 1, 4'hF, 2'd1, 3'd0, 0, 1, "m1w1_t4");
        idle(2, "idle");

        // Three waits on I/O, then none.
        for (int i = 0; i < 6; i++) step(1, 0, 4'hF, 2'd0, 3'd3, 0, 1, "io3");
        idle(2, "idle");
        for (int i = 0; i < 4; i++) step(1, 0, 4'hF, 2'd0, 3'd0, 0, 1, "io0");
        idle(2, "idle");

        // Interrupt acknowledge: only the M1 start counts.
        step(0, 1, 4'hF, 2'd1, 3'd5, 0, 1, "inta_m1");
        for (int i = 0; i < 4; i++) step(0, 0, 4'hF, 2'd1, 3'd5, 0, 1, "inta_iorq");
        idle(2, "idle");

        // External request shorter than the timeout.
        for (int i = 0; i < 3; i++) step(1, 1, 4'b1101, 2'd0, 3'd0, 0, 1, "ext_short");
        idle(2, "ext_release");

        // External request running into the timeout, then clear and re-request.
        for (int i = 0; i < 10; i++) step(1, 1, 4'b1110, 2'd0, 3'd0, 0, 1, "ext_timeout");
        idle(2, "to_sticky");
        step(1, 1, 4'hF, 2'd0, 3'd0, 1, 1, "to_clr");
        idle(2, "to_cleared");
        for (int i = 0; i < 3; i++) step(1, 1, 4'b1110, 2'd0, 3'd0, 0, 1, "ext_again");
        idle(2, "idle");

        // Wait count changed mid-insert only affects the next M1.
        step(0, 1, 4'hF, 2'd2, 3'd0, 0, 1, "m1w2_start");
        for (int i = 0; i < 3; i++) step(0, 1, 4'hF, 2'd0, 3'd0, 0, 1, "m1w_change");
        step(1, 1, 4'hF, 2'd0, 3'd0, 0, 1, "m1w_change");
        for (int i = 0; i < 3; i++) step(0, 1, 4'hF, 2'd0, 3'd0, 0, 1, "m1w0_next");
        idle(2, "idle");

        // Reset during the first wait clock, released with nm1 still low.
        step(0, 1, 4'hF, 2'd2, 3'd0, 0, 1, "rst_m1_t1");
        step(0, 1, 4'hF, 2'd2, 3'd0, 0, 0, "rst_mid_wait");
        step(0, 1, 4'hF, 2'd2, 3'd0, 0, 1, "rst_release_low");
        for (int i = 0; i < 3; i++) step(0, 1, 4'hF, 2'd2, 3'd0, 0, 1, "rst_no_start");
        step(1, 1, 4'hF, 2'd2, 3'd0, 0, 1, "rst_nm1_high");
        for (int i = 0; i < 4; i++) step(0, 1, 4'hF, 2'd2, 3'd0, 0, 1, "rst_next_m1");
        idle(2, "idle");

        // Random bus traffic.
        c_nm1 = 1; c_niorq = 1; c_nw = 4'hF;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) c_nm1 = !c_nm1;
            if ($urandom_range(0, 3) == 0) c_niorq = !c_niorq;
            if (c_nw == 4'hF) begin
                if ($urandom_range(0, 7) == 0) c_nw = 4'($urandom_range(0, 14));
            end else if ($urandom_range(0, 4) == 0) begin
                c_nw = 4'hF;
            end else if ($urandom_range(0, 3) == 0) begin
                c_nw = 4'($urandom_range(0, 14));
            end
            c_clr = ($urandom_range(0, 7) == 0);
            c_rst = ($urandom_range(0, 299) != 0);
            step(c_nm1, c_niorq, c_nw, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 c_clr, c_rst, "random");
        end

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wait_sequencer.md
WAIT_SEQUENCER -- requirements
Module: wait_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255: clocks an external wait request is honoured before it is masked (range 1-255).
REQ-002 clk  in  1  Z80 CPU clock; all state updates on its rising edge.
REQ-003 nrst  in  1  Reset; asynchronous, active-low.
REQ-004 nm1  in  1  Z80 /M1, active-low.
REQ-005 niorq  in  1  Z80 /IORQ, active-low.
REQ-006 nextwait  in  4  External wait requests, one per device, active-low.
REQ-007 m1_waits  in  2  Wait states inserted on each opcode fetch (0-3).
REQ-008 io_waits  in  3  Wait states inserted on each I/O cycle (0-7).
REQ-009 timeout_clr  in  1  Clears the timeout flag, active-high, one clock.
REQ-010 nwait  out  1  Z80 /WAIT, active-low.
REQ-011 timeout  out  1  Sticky flag: an external request hit TIMEOUT.

Function
REQ-012 Block SHALL register nm1 and niorq each rising edge (prev_nm1, prev_niorq) for start detection.
REQ-013 M1 start SHALL be: nm1=0 and prev_nm1=1 at a rising edge; load count <= m1_waits.
REQ-014 I/O start SHALL be: niorq=0, prev_niorq=1, nm1=1 at a rising edge; load count <= io_waits.
REQ-015 Interrupt acknowledge (nm1=0, niorq=0) SHALL not start a new count beyond the M1 start already taken.
REQ-016 States: IDLE, INSERT. IDLE->INSERT on a start with loaded count>0; start with count 0 SHALL stay IDLE.
REQ-017 In INSERT, count SHALL decrement each rising edge; INSERT->IDLE on the edge where count goes 1->0.
REQ-018 Internal wait (registered) SHALL be active exactly while in INSERT: N clocks low for N configured waits, first low clock begins at the start edge.
REQ-019 m1_waits/io_waits SHALL be sampled only at a start edge; changes mid-count SHALL not affect the running count.
REQ-020 A start detected while in INSERT SHALL reload count from the new cycle's setting (defensive; not produced by a legal Z80).
REQ-021 ext_active SHALL be combinational: any nextwait bit low and mask clear; no clock latency from nextwait to nwait.
REQ-022 nwait SHALL be low when internal wait or ext_active, else high.
REQ-023 Timeout counter (8 bits) SHALL increment each rising edge while any nextwait bit is low and mask clear; SHALL clear when all nextwait bits are high.
REQ-024 When the timeout counter reaches TIMEOUT, mask SHALL set (ext_active=0 next edge onward) and timeout SHALL set.
REQ-025 mask SHALL clear on the first rising edge with all nextwait bits high.
REQ-026 timeout SHALL clear on timeout_clr=1; if set and clear coincide, set wins.
REQ-027 Internal wait SHALL not be masked by timeout.

Reset
REQ-028 nrst=0 SHALL force immediately: state IDLE, count 0, timeout counter 0, mask 0, timeout 0, prev_nm1=1, prev_niorq=1; nwait high unless nextwait has a bit low.
REQ-029 Reset released mid-cycle (nm1 already low) SHALL not trigger a start until the next falling transition of nm1.

Verification
REQ-030 m1_waits=1: nm1 low at T1 -> nwait low exactly 1 clock (sampled low at T2 falling edge), high by T3.
REQ-031 io_waits=3, niorq low with nm1 high -> nwait low exactly 3 consecutive clocks; io_waits=0 -> nwait never low.
REQ-032 nextwait=4'b1101 held 3 clocks, released -> nwait low same half-cycle as request, high same half-cycle as release; timeout=0.
REQ-033 TIMEOUT=4, nextwait[0] held low 10 clocks -> nwait high after 4 clocks, timeout=1 until timeout_clr pulse; release then new request -> honoured again.
REQ-034 m1_waits=2, nrst pulsed low during first wait clock -> nwait high at once; no wait until next nm1 falling transition.
REQ-035 m1_waits changed 2->0 during INSERT -> current cycle still gets 2 waits; next M1 gets 0.
